// File: rtl/shift_right_seq.sv
// Multi-cycle right shifter: shifts a WIDTH-bit operand right one position per clock,
// with logical (zero) or arithmetic (sign) fill, behind a start/busy/done handshake.
module shift_right_seq #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             arith,
  input  logic [AMT_W-1:0] shamt,
  input  logic [WIDTH-1:0] dataIn,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] shiftedOut,
  output logic [1:0]       stateDbg
);

  // Handshake: start is taken only on an edge where busy=0; arith/shamt/dataIn are
  // captured on that same edge. busy stays high from the following cycle through the
  // done cycle, and shiftedOut is valid while done=1 and holds until the next accept.
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state;
  logic [AMT_W-1:0] count;
  logic             fillBit;
  logic [WIDTH-1:0] work;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      count   <= '0;
      fillBit <= 1'b0;
      work    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            work    <= dataIn;
            count   <= shamt;
            // Fill comes from the original operand's sign, frozen for the whole op.
            fillBit <= arith & dataIn[WIDTH-1];
            state   <= (shamt != '0) ? SHIFT : DONE;
          end
        end
        SHIFT: begin
          work  <= {fillBit, work[WIDTH-1:1]};
          count <= count - AMT_W'(1);
          if (count == AMT_W'(1)) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign shiftedOut = work;
  assign stateDbg   = state;

endmodule

// File: tb/tb_shift_right_seq.sv
// Bench for shift_right_seq: directed and random operations, expected results and
// timing queued at issue, compared by an independent per-cycle monitor.
`timescale 1ns/1ps
module tb_shift_right_seq;

  localparam int W = 16;

  logic          clk;
  logic          rst;
  logic          start;
  logic          arith;
  logic [3:0]    shamt;
  logic [W-1:0]  dataIn;
  logic          busy;
  logic          done;
  logic [W-1:0]  shiftedOut;
  logic [1:0]    stateDbg;

  shift_right_seq #(.WIDTH(16), .AMT_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .arith(arith), .shamt(shamt),
    .dataIn(dataIn), .busy(busy), .done(done), .shiftedOut(shiftedOut),
    .stateDbg(stateDbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  logic [W-1:0] exp_q[$];
  int           exp_e0_q[$];
  int           exp_end_q[$];
  logic [W-1:0] last_result;
  int           last_end;
  int           cyc;
  bit           mon_en;
  int           n_checks;
  int           n_fail;

  task automatic check(input bit ok, input string name, input logic [W-1:0] act,
                       input logic [W-1:0] expv);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, expv);
    end
  endtask

  function automatic logic [W-1:0] ref_shift(input logic [W-1:0] d, input int sh,
                                             input bit ar);
    if (ar) return W'($signed(d) >>> sh);
    return d >> sh;
  endfunction

  // monitor: sample shortly after every rising edge
  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (mon_en) begin
        bit busy_e;
        bit done_e;
        busy_e = 1'b0;
        done_e = 1'b0;
        foreach (exp_e0_q[i]) begin
          if (cyc >= exp_e0_q[i] && cyc <= exp_end_q[i]) busy_e = 1'b1;
          if (cyc == exp_end_q[i]) done_e = 1'b1;
        end
        check(busy == busy_e, "busy", W'(busy), W'(busy_e));
        check(done == done_e, "done", W'(done), W'(done_e));
        if (done_e && exp_q.size() > 0) begin
          check(shiftedOut == exp_q[0], "result", shiftedOut, exp_q[0]);
          last_result = exp_q[0];
          void'(exp_q.pop_front());
          void'(exp_e0_q.pop_front());
          void'(exp_end_q.pop_front());
        end else if (!busy_e) begin
          check(shiftedOut == last_result, "hold", shiftedOut, last_result);
        end
      end
    end
  end

  // driver tasks: each is entered right after a falling edge
  task automatic wait_idle();
    while (cyc <= last_end) @(negedge clk);
  endtask

  task automatic push_op(input logic [W-1:0] d, input int sh, input bit ar, input int e0);
    exp_q.push_back(ref_shift(d, sh, ar));
    exp_e0_q.push_back(e0);
    exp_end_q.push_back(e0 + sh);
    last_end = e0 + sh;
  endtask

  task automatic issue(input logic [W-1:0] d, input int sh, input bit ar);
    wait_idle();
    start  = 1'b1;
    dataIn = d;
    shamt  = 4'(sh);
    arith  = ar;
    push_op(d, sh, ar, cyc + 1);
    @(negedge clk);
    start  = 1'b0;
    dataIn = W'($urandom);
    shamt  = 4'($urandom_range(0, 15));
    arith  = 1'($urandom_range(0, 1));
  endtask

  // start while busy must be ignored
  task automatic poke(input logic [W-1:0] d, input bit ar);
    if (cyc <= last_end) begin
      start  = 1'b1;
      dataIn = d;
      shamt  = 4'($urandom_range(0, 15));
      arith  = ar;
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  // start held high across two ops
  task automatic held_pair(input logic [W-1:0] d1, input int s1, input bit a1,
                           input logic [W-1:0] d2, input int s2, input bit a2);
    int e0b;
    wait_idle();
    start  = 1'b1;
    dataIn = d1;
    shamt  = 4'(s1);
    arith  = a1;
    push_op(d1, s1, a1, cyc + 1);
    e0b = cyc + 1 + s1 + 2;
    @(negedge clk);
    dataIn = d2;
    shamt  = 4'(s2);
    arith  = a2;
    push_op(d2, s2, a2, e0b);
    while (cyc < e0b) @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    exp_e0_q.delete();
    exp_end_q.delete();
    last_result = '0;
    last_end    = -1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "timeout");
  end

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    mon_en      = 1'b0;
    last_result = '0;
    last_end    = -1;
    rst    = 1'b1;
    start  = 1'b0;
    arith  = 1'b0;
    shamt  = '0;
    dataIn = '0;
    repeat (3) @(negedge clk);
    check(busy == 1'b0, "reset_busy", W'(busy), '0);
    check(done == 1'b0, "reset_done", W'(done), '0);
    check(shiftedOut == '0, "reset_out", shiftedOut, '0);
    rst    = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    // directed cases
    issue(16'h8000, 4, 1'b0);
    issue(16'h8000, 4, 1'b1);
    issue(16'hFFFF, 15, 1'b1);
    issue(16'h7FFF, 15, 1'b1);
    issue(16'h0013, 0, 1'b0);
    repeat (2) @(negedge clk);

    issue(16'h00F0, 15, 1'b0);
    @(negedge clk);
    poke(16'hFFFF, 1'b1);
    repeat (3) @(negedge clk);

    issue(16'h1234, 8, 1'b0);
    @(negedge clk);
    do_reset();
    @(negedge clk);
    issue(16'h0013, 1, 1'b0);

    held_pair(16'h0005, 1, 1'b0, 16'h0013, 2, 1'b0);
    wait_idle();
    repeat (3) @(negedge clk);

    // random traffic
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 9) == 0)
        held_pair(W'($urandom), $urandom_range(0, 15), 1'($urandom_range(0, 1)),
                  W'($urandom), $urandom_range(0, 15), 1'($urandom_range(0, 1)));
      else
        issue(W'($urandom), $urandom_range(0, 15), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) poke(W'($urandom), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 15) == 0) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        do_reset();
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    wait_idle();
    repeat (4) @(negedge clk);
    check(exp_q.size() == 0, "drain", W'(exp_q.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
